// File: rtl/wb_stage.sv
// Write-back stage: final pipeline register, register-file write port, ID-stage
// bypass, and a commit-trace FIFO whose fullness can stall retirement.
module wb_stage #(
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    output logic        wb_allowin_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        rf_we_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic [31:0] rf_wdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_waddr_o,
    output logic [31:0] fwd_wdata_o,
    output logic        trace_valid_o,
    input  logic        trace_ready_i,
    output logic [31:0] trace_pc_o,
    output logic        trace_rf_we_o,
    output logic [4:0]  trace_waddr_o,
    output logic [31:0] trace_wdata_o,
    output logic [31:0] retire_cnt_o
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(TRACE_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_t;

    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   retire_cnt_q, retire_cnt_d;

    trace_t        fifo_q [TRACE_DEPTH];
    trace_t        head;
    trace_t        push_entry;
    logic          pop, commit, load, writes_rf;
    logic          unused_ok;

    // The instruction word travels with the stage but nothing downstream consumes it.
    assign unused_ok = ^inst_q;

    always_comb begin
        writes_rf     = rf_we_q && (waddr_q != 5'd0);
        trace_valid_o = (count_q != '0);
        pop           = trace_valid_o && trace_ready_i;
        // A full FIFO can still accept the commit when its head leaves this cycle.
        commit        = wb_valid_q && ((count_q < FULL_CNT) || pop);
        wb_allowin_o  = !wb_valid_q || commit;
        load          = mem_valid_i && wb_allowin_o;

        rf_we_o       = commit && writes_rf;
        rf_waddr_o    = waddr_q;
        rf_wdata_o    = wdata_q;
        fwd_valid_o   = wb_valid_q && writes_rf;
        fwd_waddr_o   = waddr_q;
        fwd_wdata_o   = wdata_q;
        retire_cnt_o  = retire_cnt_q;

        push_entry.pc    = pc_q;
        push_entry.rf_we = writes_rf;
        push_entry.waddr = waddr_q;
        push_entry.wdata = wdata_q;

        // Storage is never cleared, so mask it while the FIFO is empty.
        head          = fifo_q[rd_ptr_q];
        trace_pc_o    = trace_valid_o ? head.pc    : 32'd0;
        trace_rf_we_o = trace_valid_o ? head.rf_we : 1'b0;
        trace_waddr_o = trace_valid_o ? head.waddr : 5'd0;
        trace_wdata_o = trace_valid_o ? head.wdata : 32'd0;
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        rf_we_d    = rf_we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (load) begin
            wb_valid_d = 1'b1;
            pc_d       = pc_i;
            inst_d     = inst_i;
            rf_we_d    = rf_we_i;
            waddr_d    = rf_waddr_i;
            wdata_d    = rf_wdata_i;
        end else if (commit) begin
            wb_valid_d = 1'b0;
        end

        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = commit ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({commit, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        retire_cnt_d = retire_cnt_q + {31'd0, commit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            pc_q         <= '0;
            inst_q       <= '0;
            rf_we_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            rf_we_q      <= rf_we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: an accepted instruction queues its expected trace entry and
// register write; a monitor pops and compares them as the DUT emits them.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i;
    logic        wb_allowin_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic [31:0] rf_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_waddr_o;
    logic [31:0] fwd_wdata_o;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic        trace_rf_we_o;
    logic [4:0]  trace_waddr_o;
    logic [31:0] trace_wdata_o;
    logic [31:0] retire_cnt_o;

    always #5 clk = ~clk;

    wb_stage #(.TRACE_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid_i   (mem_valid_i),
        .wb_allowin_o  (wb_allowin_o),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .rf_we_i       (rf_we_i),
        .rf_waddr_i    (rf_waddr_i),
        .rf_wdata_i    (rf_wdata_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .fwd_valid_o   (fwd_valid_o),
        .fwd_waddr_o   (fwd_waddr_o),
        .fwd_wdata_o   (fwd_wdata_o),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_pc_o    (trace_pc_o),
        .trace_rf_we_o (trace_rf_we_o),
        .trace_waddr_o (trace_waddr_o),
        .trace_wdata_o (trace_wdata_o),
        .retire_cnt_o  (retire_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_tr[$];
    exp_t exp_rf[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   rf_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rf_we_o) rf_pulses++;
        if (rst_n) begin
            if (trace_valid_o && trace_ready_i) begin
                if (exp_tr.size() == 0) begin
                    check("trace_unexpected", 32'(trace_valid_o), 32'd0);
                end else begin
                    e = exp_tr.pop_front();
                    check("trace_pc", trace_pc_o, e.pc);
                    check("trace_rf_we", 32'(trace_rf_we_o), 32'(e.we));
                    check("trace_waddr", 32'(trace_waddr_o), 32'(e.waddr));
                    check("trace_wdata", trace_wdata_o, e.wdata);
                end
            end
            if (rf_we_o) begin
                if (exp_rf.size() == 0) begin
                    check("rf_unexpected", 32'(rf_we_o), 32'd0);
                end else begin
                    e = exp_rf.pop_front();
                    check("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
                    check("rf_wdata", rf_wdata_o, e.wdata);
                end
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                        input logic [31:0] wdata);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        mem_valid_i = 1'b1;
        pc_i        = pc;
        inst_i      = $urandom;
        rf_we_i     = we;
        rf_waddr_i  = waddr;
        rf_wdata_i  = wdata;
        #2;
        while (!wb_allowin_o && waited < 50) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!wb_allowin_o) begin
            check("send_timeout", 32'(wb_allowin_o), 32'd1);
            return;
        end
        e.pc    = pc;
        e.we    = we && (waddr != 5'd0);
        e.waddr = waddr;
        e.wdata = wdata;
        exp_tr.push_back(e);
        if (e.we) exp_rf.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        mem_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_tr.size() != 0 || trace_valid_o) && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({tag, "_trace_left"}, 32'(exp_tr.size()), 32'd0);
        check({tag, "_rf_left"}, 32'(exp_rf.size()), 32'd0);
        check({tag, "_trace_valid"}, 32'(trace_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n         = 1'b0;
        mem_valid_i   = 1'b0;
        pc_i          = '0;
        inst_i        = '0;
        rf_we_i       = 1'b0;
        rf_waddr_i    = '0;
        rf_wdata_i    = '0;
        trace_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("rst_rf_we", 32'(rf_we_o), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid_o), 32'd0);
        check("rst_trace_valid", 32'(trace_valid_o), 32'd0);
        check("rst_allowin", 32'(wb_allowin_o), 32'd1);
        check("rst_trace_pc", trace_pc_o, 32'd0);
        check("rst_trace_wdata", trace_wdata_o, 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
        check("rst_rf_wdata", rf_wdata_o, 32'd0);
        check("rst_fwd_waddr", 32'(fwd_waddr_o), 32'd0);
        check("rst_fwd_wdata", fwd_wdata_o, 32'd0);
        check("rst_retire", retire_cnt_o, 32'd0);

        // back-to-back streaming, pointers wrap twice
        trace_ready_i = 1'b1;
        p0 = rf_pulses;
        for (int i = 0; i < 10; i++)
            send(32'h1000 + 32'(i * 4), 1'b1, 5'(i + 1), $urandom);
        idle();
        drain("stream");
        check("stream_retire", retire_cnt_o, 32'd10);
        check("stream_rf_pulses", 32'(rf_pulses - p0), 32'd10);

        // write to r0 retires but never reaches the register file or bypass
        p0 = rf_pulses;
        send(32'h2000, 1'b1, 5'd0, 32'h1234_5678);
        @(negedge clk);
        mem_valid_i = 1'b0;
        #2;
        check("r0_fwd_valid", 32'(fwd_valid_o), 32'd0);
        check("r0_rf_we", 32'(rf_we_o), 32'd0);
        drain("r0");
        check("r0_retire", retire_cnt_o, 32'd11);
        check("r0_rf_pulses", 32'(rf_pulses - p0), 32'd0);

        // back-pressure: four fill the FIFO, the fifth stalls in WB, the sixth waits
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h3000 + 32'(i * 4), 1'b1, 5'(i + 10), $urandom);
        send(32'h3010, 1'b1, 5'd5, 32'hA5A5_A5A5);
        @(negedge clk);
        pc_i       = 32'h3014;
        inst_i     = $urandom;
        rf_we_i    = 1'b1;
        rf_waddr_i = 5'd20;
        rf_wdata_i = 32'hCAFE_0006;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_allowin", 32'(wb_allowin_o), 32'd0);
            check("bp_rf_we", 32'(rf_we_o), 32'd0);
            check("bp_fwd_valid", 32'(fwd_valid_o), 32'd1);
            check("bp_fwd_waddr", 32'(fwd_waddr_o), 32'd5);
            check("bp_fwd_wdata", fwd_wdata_o, 32'hA5A5_A5A5);
            check("bp_retire", retire_cnt_o, 32'd15);
            @(negedge clk);
        end
        trace_ready_i = 1'b1;
        #2;
        check("bp_pop_allowin", 32'(wb_allowin_o), 32'd1);
        check("bp_pop_rf_we", 32'(rf_we_o), 32'd1);
        begin
            exp_t e;
            e.pc = 32'h3014; e.we = 1'b1; e.waddr = 5'd20; e.wdata = 32'hCAFE_0006;
            exp_tr.push_back(e);
            exp_rf.push_back(e);
        end
        @(posedge clk);
        idle();
        drain("bp");
        check("bp_retire_end", retire_cnt_o, 32'd17);

        // reset with a full FIFO and a held instruction
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'h4000 + 32'(i * 4), 1'b1, 5'(i + 1), $urandom);
        idle();
        #2;
        check("mr_full_allowin", 32'(wb_allowin_o), 32'd0);
        p0 = rf_pulses;
        @(negedge clk);
        rst_n = 1'b0;
        exp_tr.delete();
        exp_rf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("mr_trace_valid", 32'(trace_valid_o), 32'd0);
        check("mr_retire", retire_cnt_o, 32'd0);
        check("mr_allowin", 32'(wb_allowin_o), 32'd1);
        check("mr_fwd_valid", 32'(fwd_valid_o), 32'd0);
        trace_ready_i = 1'b1;
        @(negedge clk);
        #2;
        check("mr_trace_valid_rdy", 32'(trace_valid_o), 32'd0);
        check("mr_rf_pulses", 32'(rf_pulses - p0), 32'd0);

        // retire counter wrap, then more pointer wrapping
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check("wrap_preload", retire_cnt_o, 32'hFFFF_FFFF);
        send(32'h5000, 1'b1, 5'd7, $urandom);
        idle();
        drain("wrap1");
        check("wrap_retire_zero", retire_cnt_o, 32'd0);
        for (int i = 1; i < 9; i++)
            send(32'h5000 + 32'(i * 4), i[0], 5'(i + 20), $urandom);
        idle();
        drain("wrap9");
        check("wrap_retire_8", retire_cnt_o, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter TRACE_DEPTH, default 4, sets the commit-trace FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 mem_valid_i  input  1  the MEM/WB register holds a valid instruction.
REQ-005 wb_allowin_o  output  1  WB can accept the MEM/WB contents this cycle.
REQ-006 pc_i, inst_i  input  32 each  PC and instruction word from MEM/WB.
REQ-007 rf_we_i, rf_waddr_i, rf_wdata_i  input  1/5/32  register-write request from MEM/WB.
REQ-008 rf_we_o, rf_waddr_o, rf_wdata_o  output  1/5/32  register-file write port.
REQ-009 fwd_valid_o, fwd_waddr_o, fwd_wdata_o  output  1/5/32  bypass to the ID stage.
REQ-010 trace_valid_o, trace_ready_i  output/input  1/1  commit-trace handshake.
REQ-011 trace_pc_o, trace_rf_we_o, trace_waddr_o, trace_wdata_o  output  32/1/5/32  head entry of the trace FIFO.
REQ-012 retire_cnt_o  output  32  count of committed instructions.

Function
REQ-013 The WB register (wb_valid plus the captured pc, inst, rf_we, waddr, wdata) SHALL load at the clock edge when mem_valid_i && wb_allowin_o.
- It SHALL clear wb_valid at the edge when the held instruction commits and no new one loads.
- It SHALL hold otherwise.
REQ-014 commit = wb_valid && (fifo_count < TRACE_DEPTH || (trace_valid_o && trace_ready_i)).
REQ-015 wb_allowin_o = !wb_valid || commit (combinational); a stalled WB SHALL back-pressure MEM/WB.
REQ-016 Register-file write port:
- rf_we_o = commit && held rf_we && held waddr != 0, combinational, in the commit cycle only.
- rf_waddr_o and rf_wdata_o SHALL present the held values.
REQ-017 fwd_valid_o = wb_valid && held rf_we && held waddr != 0, independent of commit.
- fwd_waddr_o and fwd_wdata_o SHALL present the held values.
REQ-018 On commit, the held {pc, rf_we && waddr != 0, waddr, wdata} SHALL be pushed into the FIFO at the same edge.
REQ-019 Pop rule: pop = trace_valid_o && trace_ready_i, and trace_valid_o = (fifo_count != 0).
- The trace_* outputs SHALL show the oldest entry, read combinationally from storage.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged, and the pushed entry SHALL queue behind the popped one.
REQ-021 Pointer and count widths:
- Read/write pointers are log2(TRACE_DEPTH) bits and SHALL wrap modulo TRACE_DEPTH.
- fifo_count is log2(TRACE_DEPTH)+1 bits and ranges 0..TRACE_DEPTH.
REQ-022 Full FIFO with no pop that cycle: commit SHALL be 0, the WB register SHALL hold, and wb_allowin_o SHALL be 0.
REQ-023 Empty FIFO: trace_ready_i SHALL be ignored, and no pop or underflow SHALL occur.
REQ-024 Trace latency: an instruction committing at edge N SHALL appear on trace_valid_o from cycle N+1 at the earliest, in commit order.
REQ-025 retire_cnt_o SHALL increment by 1 at every commit edge and wrap from 0xFFFFFFFF to 0.
REQ-026 Each instruction SHALL commit exactly once; rf_we_o SHALL never assert twice for the same instruction.

Reset
REQ-027 While rst_n=0 at a clock edge:
- wb_valid, fifo_count, both pointers and retire_cnt_o SHALL become 0.
- The held fields SHALL become 0.
REQ-028 After reset:
- rf_we_o, fwd_valid_o and trace_valid_o SHALL be 0.
- wb_allowin_o SHALL be 1.
- The trace_*, rf_waddr_o, rf_wdata_o and fwd_* data outputs SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard the held instruction and all FIFO entries without a register-file write.
REQ-030 FIFO storage contents need not be cleared.

Verification
REQ-031 Streaming: 10 back-to-back instructions with trace_ready_i=1 -> one rf_we_o pulse per instruction, retire_cnt_o=10, trace entries in order with matching pc.
REQ-032 r0 write: rf_we_i=1, rf_waddr_i=0, rf_wdata_i=0x12345678 -> rf_we_o=0, fwd_valid_o=0, trace_rf_we_o=0, retire_cnt_o increments.
REQ-033 Back-pressure (TRACE_DEPTH=4, trace_ready_i=0):
- Sending 6 instructions -> 4 commit, the 5th holds in WB with wb_allowin_o=0, and the 6th waits in MEM/WB.
- Raising trace_ready_i -> the 5th commits in the first pop cycle, and all 6 trace entries emerge in order.
REQ-034 Forwarding: instruction held in WB with rf_waddr=5 and wdata=0xA5A5A5A5 while stalled -> fwd_valid_o=1 with those values every stall cycle, and exactly one rf_we_o pulse when it commits.
REQ-035 Reset mid-stream: rst_n=0 with a full FIFO and wb_valid=1 -> next cycle trace_valid_o=0, retire_cnt_o=0, wb_allowin_o=1, and no rf_we_o pulse.
REQ-036 Wrap: preload retire_cnt_o=0xFFFFFFFF via a forced value, then commit 1 instruction -> retire_cnt_o=0; pointers wrap correctly after 9 push/pop pairs.
